// File: rtl/mlp_seq_engine_if.sv
// rtl/mlp_seq_engine_if.sv - sample, parameter-load and result signals of mlp_seq_engine
interface mlp_seq_engine_if #(
    parameter int DATA_W  = 32,
    parameter int INPUTS  = 9,
    parameter int OUTPUTS = 2,
    parameter int ADDR_W  = 8,
    parameter int CLASS_W = 1
);
    logic                        in_valid;
    logic                        in_ready;
    logic [INPUTS*DATA_W-1:0]    in_data;
    logic                        wr_en;
    logic                        wr_layer;
    logic [ADDR_W-1:0]           wr_addr;
    logic [DATA_W-1:0]           wr_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUTPUTS*DATA_W-1:0]   out_data;
    logic [CLASS_W-1:0]          out_class;
    logic                        busy;

    modport master (
        output in_valid, in_data, wr_en, wr_layer, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, out_data, out_class, busy
    );

    modport slave (
        input  in_valid, in_data, wr_en, wr_layer, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, out_data, out_class, busy
    );
endinterface

// File: rtl/mlp_seq_engine.sv
// rtl/mlp_seq_engine.sv - two-layer fixed-point MLP, one shared MAC per cycle;
// define MLP_SEQ_SATURATE_EN to clamp neuron results instead of wrapping them.
module mlp_seq_engine #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 20,
    parameter int INPUTS    = 9,
    parameter int HIDDEN    = 8,
    parameter int OUTPUTS   = 2,
    parameter int ADDR_W    = 8,
    parameter int CLASS_W   = 1
) (
    input logic              clk,
    input logic              rst_n,
    mlp_seq_engine_if.slave  bus
);
    localparam int ACC_W   = DATA_W + 16;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int HID_N   = HIDDEN * (INPUTS + 1);
    localparam int OUT_N   = OUTPUTS * (HIDDEN + 1);
    localparam int MAX_DIM = (INPUTS > HIDDEN) ? ((INPUTS > OUTPUTS) ? INPUTS : OUTPUTS)
                                               : ((HIDDEN > OUTPUTS) ? HIDDEN : OUTPUTS);
    localparam int CNT_W   = $clog2(MAX_DIM + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               neuron_q, neuron_d;
    logic [CNT_W-1:0]               term_q, term_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [INPUTS*DATA_W-1:0]       x_q, x_d;
    logic [HIDDEN*DATA_W-1:0]       hid_q, hid_d;
    logic [HID_N*DATA_W-1:0]        hw_q, hw_d;
    logic [OUT_N*DATA_W-1:0]        ow_q, ow_d;
    logic [OUTPUTS*DATA_W-1:0]      out_data_q, out_data_d;
    logic [CLASS_W-1:0]             out_class_q, out_class_d;
    logic signed [DATA_W-1:0]       best_q, best_d;
    logic                           out_valid_q, out_valid_d;
    logic                           in_ready_q, in_ready_d;
    logic                           busy_q, busy_d;

    logic                           in_hid;
    int                             nq, kq, prev_n, neur_n;
    logic signed [DATA_W-1:0]       a_op, w_op, b_op, res;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        term_val, base, sum, act;

    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef MLP_SEQ_SATURATE_EN
        if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        else                  return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        neuron_d    = neuron_q;
        term_d      = term_q;
        acc_d       = acc_q;
        x_d         = x_q;
        hid_d       = hid_q;
        hw_d        = hw_q;
        ow_d        = ow_q;
        out_data_d  = out_data_q;
        out_class_d = out_class_q;
        best_d      = best_q;
        out_valid_d = out_valid_q;

        in_hid = (state_q == S_HID);
        nq     = int'(neuron_q);
        kq     = int'(term_q);
        prev_n = in_hid ? INPUTS : HIDDEN;
        neur_n = in_hid ? HIDDEN : OUTPUTS;

        // Operand muxing feeds the one shared multiplier from whichever layer is active
        if (in_hid) begin
            a_op = x_q[kq*DATA_W +: DATA_W];
            w_op = hw_q[(nq*INPUTS + kq)*DATA_W +: DATA_W];
            b_op = hw_q[(HIDDEN*INPUTS + nq)*DATA_W +: DATA_W];
        end else begin
            a_op = hid_q[kq*DATA_W +: DATA_W];
            w_op = ow_q[(nq*HIDDEN + kq)*DATA_W +: DATA_W];
            b_op = ow_q[(OUTPUTS*HIDDEN + nq)*DATA_W +: DATA_W];
        end

        prod     = PROD_W'(a_op) * PROD_W'(w_op);
        term_val = ACC_W'(prod >>> FRAC_BITS);
        base     = (kq == 0) ? ACC_W'(b_op) : acc_q;
        sum      = base + term_val;
        act      = (in_hid && sum < 0) ? '0 : sum;
        res      = narrow(act);

        case (state_q)
            S_IDLE: begin
                if (bus.wr_en) begin
                    if (!bus.wr_layer) begin
                        if (int'(bus.wr_addr) < HID_N)
                            hw_d[int'(bus.wr_addr)*DATA_W +: DATA_W] = bus.wr_data;
                    end else if (int'(bus.wr_addr) < OUT_N) begin
                        ow_d[int'(bus.wr_addr)*DATA_W +: DATA_W] = bus.wr_data;
                    end
                end
                if (bus.in_valid && in_ready_q) begin
                    x_d      = bus.in_data;
                    state_d  = S_HID;
                    neuron_d = '0;
                    term_d   = '0;
                end
            end
            S_HID, S_OUT: begin
                acc_d = sum;
                if (kq == prev_n - 1) begin
                    term_d = '0;
                    if (in_hid) begin
                        hid_d[nq*DATA_W +: DATA_W] = res;
                    end else begin
                        out_data_d[nq*DATA_W +: DATA_W] = res;
                        // Strict compare keeps the lowest index on ties
                        if (nq == 0 || res > best_q) begin
                            best_d      = res;
                            out_class_d = CLASS_W'(neuron_q);
                        end
                    end
                    if (nq == neur_n - 1) begin
                        neuron_d = '0;
                        state_d  = in_hid ? S_OUT : S_DONE;
                    end else begin
                        neuron_d = neuron_q + CNT_W'(1);
                    end
                end else begin
                    term_d = term_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d == S_HID) || (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            neuron_q    <= '0;
            term_q      <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            hid_q       <= '0;
            hw_q        <= '0;
            ow_q        <= '0;
            out_data_q  <= '0;
            out_class_q <= '0;
            best_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            neuron_q    <= neuron_d;
            term_q      <= term_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            hid_q       <= hid_d;
            hw_q        <= hw_d;
            ow_q        <= ow_d;
            out_data_q  <= out_data_d;
            out_class_q <= out_class_d;
            best_q      <= best_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_class = out_class_q;
endmodule
